uart_tx_fifo_drain: RTL

Serializes bytes from the bridge's synchronous TX FIFO onto the UART line as 8N1 frames at a fixed baud. It sits between the FIFO read port and the `tx` pin. It pops exactly one byte per frame, and it sends frames back-to-back with no idle gap while data is available. Hardware flow control comes from an asynchronous `cts_n` input, which is synchronized internally.

---
 rtl/uart_tx_fifo_drain.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo_drain.sv
// uart_tx_fifo_drain
//   Drains a show-ahead synchronous FIFO onto a UART line as 8N1 frames.
//   One byte is popped per frame. Frames run back-to-back with no idle gap
//   while data is available, tx_enable is high and the link is clear to send.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per bit (>= 2)
//   DATA_WIDTH    data bits per frame, sent LSB first
//
// Ports
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   tx_enable     permits new frames; only looked at on frame boundaries
//   cts_n         clear-to-send, active low, asynchronous (synchronized here)
//   fifo_empty    FIFO empty flag
//   fifo_rd_data  FIFO head word, valid while fifo_empty = 0
//   fifo_rd_en    pop strobe (combinational), one cycle per frame
//   tx            serial line (registered), idles high
//   tx_busy       high from start bit through end of stop bit (registered)
//   tx_done       one-cycle pulse in the cycle after a stop bit (registered)
module uart_tx_fifo_drain #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tx_enable,
    input  logic                  cts_n,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  fifo_rd_en,
    output logic                  tx,
    output logic                  tx_busy,
    output logic                  tx_done
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t                 state_q,   state_d;
    logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
    logic [IW-1:0]          idx_q,     idx_d;
    logic [DATA_WIDTH-1:0]  shift_q,   shift_d;
    logic                   tx_q,      tx_d;
    logic                   busy_q,    busy_d;
    logic                   done_q,    done_d;
    // Synchronizer resets to "not clear" so nothing is popped during reset
    // or in the two cycles after release.
    logic                   cts_meta_q, cts_sync_q;

    logic                   can_start;
    logic                   bit_end;
    logic [DATA_WIDTH-1:0]  shifted;

    always_comb begin
        can_start  = tx_enable & ~fifo_empty & ~cts_sync_q;
        bit_end    = (bit_cnt_q == BIT_LAST);
        shifted    = shift_q >> 1;

        state_d    = state_q;
        bit_cnt_d  = (state_q == S_IDLE || bit_end) ? '0 : bit_cnt_q + CW'(1);
        idx_d      = idx_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        fifo_rd_en = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (can_start) begin
                    fifo_rd_en = 1'b1;
                    shift_d    = fifo_rd_data;
                    state_d    = S_START;
                    tx_d       = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    idx_d   = '0;
                    tx_d    = shift_q[0];
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        shift_d = shifted;
                        tx_d    = shifted[0];
                    end
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    done_d = 1'b1;
                    // Pop in the final stop cycle so the next start bit
                    // follows with no gap; busy stays high across frames.
                    if (can_start) begin
                        fifo_rd_en = 1'b1;
                        shift_d    = fifo_rd_data;
                        state_d    = S_START;
                        tx_d       = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cts_meta_q <= 1'b1;
            cts_sync_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            cts_meta_q <= cts_n;
            cts_sync_q <= cts_meta_q;
        end
    end

    assign tx      = tx_q;
    assign tx_busy = busy_q;
    assign tx_done = done_q;

endmodule
